// File: rtl/console_pkg.sv
// Shared constants for the console receive path: UART register layout,
// default FIFO depth and the poll-FSM state encoding.
package console_pkg;

  localparam int UART_NODATA_BIT   = 31;
  localparam int RXF_DEPTH_DEFAULT = 16;

  typedef enum logic {
    RXF_IDLE  = 1'b0,
    RXF_DRAIN = 1'b1
  } rxf_state_e;

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x 8 register array: one synchronous write port, one asynchronous read port.
module rx_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/console_rx_fifo.sv
// Console receive buffer: polls the UART data register, queues bytes in a
// circular FIFO and presents the oldest one to the CPU (0 when empty).
module console_rx_fifo
  import console_pkg::*;
#(
  parameter int DEPTH  = RXF_DEPTH_DEFAULT,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     uart_dat_do,
  output logic            uart_dat_re,
  input  logic            cpu_re,
  output logic [31:0]     cpu_dat,
  output logic            cpu_valid,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  input  logic            clr_overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  rxf_state_e        state_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, uart_re_q, valid_q;

  logic       pop, byte_avail, room, push, drop;
  logic [7:0] head_byte;
  logic       unused_dat_bits;

  assign unused_dat_bits = ^uart_dat_do[30:8];

  always_comb begin
    pop        = cpu_re && (count_q != '0);
    byte_avail = (state_q == RXF_IDLE) && !uart_dat_do[UART_NODATA_BIT];
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    room       = (count_q != FULL_CNT) || pop;
    push       = byte_avail && room;
    drop       = byte_avail && !room;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RXF_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      uart_re_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        RXF_IDLE: begin
          uart_re_q <= byte_avail;
          if (byte_avail) state_q <= RXF_DRAIN;
        end
        RXF_DRAIN: begin
          uart_re_q <= 1'b0;
          state_q   <= RXF_IDLE;
        end
        default: begin
          uart_re_q <= 1'b0;
          state_q   <= RXF_IDLE;
        end
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (clr_overflow) overflow_q <= 1'b0;
      else if (drop)    overflow_q <= 1'b1;
    end
  end

  rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (uart_dat_do[7:0]),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_byte)
  );

  assign uart_dat_re = uart_re_q;
  assign cpu_valid   = valid_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign cpu_dat     = (count_q != '0) ? {24'h0, head_byte} : '0;

endmodule

// File: doc/console_rx_fifo.md
# console_rx_fifo

Receive buffer between the `simpleuart` console and the CPU core. It polls the UART data register, drains each received byte into a small circular FIFO, and presents the oldest byte to the CPU. The CPU "read char" instruction can then pop bytes without losing characters that arrive while it is busy. An empty FIFO reads as 0, which keeps the CPU's existing non-blocking "0 = no data" semantics.

## Interface
- `DEPTH`, 16, FIFO entries; must be a power of two, minimum 2.
- `ADDR_W`, 4, log2(`DEPTH`).

- `clk`  in  1  system clock (16 MHz).
- `resetn`  in  1  asynchronous, active-low reset.
- `uart_dat_do`  in  32  UART `reg_dat_do`. Bit 31 set means no byte is pending; otherwise bits [7:0] hold the byte.
- `uart_dat_re`  out  1  one-cycle pulse to UART `reg_dat_re`; consumes the pending byte.
- `cpu_re`  in  1  pop request, one-cycle pulse from the CPU.
- `cpu_dat`  out  32  head byte zero-extended; 32'h0 when empty.
- `cpu_valid`  out  1  FIFO non-empty.
- `count`  out  `ADDR_W`+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky: a byte was dropped.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- Poll FSM, two states:
  - IDLE: if `uart_dat_do[31]`==0, assert `uart_dat_re` next cycle, then go to DRAIN.
    - If the FIFO has room, write `uart_dat_do[7:0]` at `wr_ptr` and increment `wr_ptr`.
    - If the FIFO is full, drop the byte and set `overflow`.
  - DRAIN: deassert `uart_dat_re` and ignore `uart_dat_do`, because the UART clears its valid flag one cycle after `re`. Return to IDLE.
- Room check: `count` < `DEPTH`, or `cpu_re` is accepted in the same cycle. A simultaneous pop frees the slot, so the byte is accepted.
- Pop: when `cpu_re`=1 and `count`>0, increment `rd_ptr`. When `count`==0, `cpu_re` is ignored with no underflow and no pointer change.
- Pointers are `ADDR_W` bits and wrap modulo `DEPTH`. `count` is tracked separately:
  - push only: +1
  - pop only: −1
  - both: unchanged
- `cpu_dat` = {24'h0, `mem[rd_ptr]`} when `count`>0, else 0. It is a combinational read of the register array.
- `clr_overflow` has priority over a same-cycle drop: the flag ends the cycle cleared.
- Reset values: `uart_dat_re`=0, `cpu_valid`=0, `cpu_dat`=0, `count`=0, `overflow`=0, FSM=IDLE, both pointers=0. Memory contents are don't-care.
- Reset mid-operation discards all buffered bytes. A byte whose `re` pulse was cut short remains pending in the UART and is drained after reset releases.

## Timing
- Byte visible on `uart_dat_do` in cycle n (FSM in IDLE):
  - `uart_dat_re`=1 in cycle n+1.
  - `cpu_valid`=1 and `cpu_dat` valid in cycle n+1.
  - FSM back in IDLE in cycle n+2.
- Maximum accept rate is one byte per 2 cycles, far above the UART rate.
- Pop latency: `cpu_re` in cycle m; `cpu_dat` shows the next entry, or 0, from cycle m+1.
- `count` and `cpu_valid` are registered and update on the edge after the push or pop.

## Structure
- Shared package `console_pkg`:
  - `UART_NODATA_BIT`=31.
  - `RXF_DEPTH_DEFAULT`=16.
  - Poll-FSM state constants `RXF_IDLE`, `RXF_DRAIN`.
- Sub-module `rx_fifo_mem`: `DEPTH`×8 register array with one synchronous write port and one asynchronous read port. Pointers, count and FSM stay in `console_rx_fifo`.

## Test plan
- Single byte: `uart_dat_do`=32'h41 for 2 cycles, then 32'hFFFFFFFF → one `uart_dat_re` pulse, `count`=1, `cpu_dat`=32'h41. Pulse `cpu_re` → `count`=0, `cpu_dat`=0, `cpu_valid`=0.
- Ordering and wrap: push 0x01..0x14 (20 bytes), popping after every 4th push so the FIFO never fills → pops return 0x01..0x14 in order, `overflow`=0, pointers wrap once.
- Full: push 17 bytes with no pops → `count`=16, byte 17 dropped but still drained (`uart_dat_re` pulses 17 times), `overflow`=1. Pulse `clr_overflow` → `overflow`=0.
- Full with simultaneous pop: with `count`=16, new byte in IDLE and `cpu_re` in the same cycle → byte accepted, `count` stays 16, `overflow`=0.
- Empty pop: `cpu_re` pulsed 3× with `count`=0 → `count` stays 0, pointers unchanged, `cpu_dat`=0.
- Reset mid-stream: with `count`=5, assert `resetn`=0 asynchronously between edges → all outputs at reset values immediately. Release → next byte lands at `count`=1.
